// File: rtl/cic_comp_fir_pkg.sv
// Shared widths, FSM encoding and the CIC droop-compensation coefficients.
package cic_comp_pkg;

    localparam int IN_W   = 19;
    localparam int COEF_W = 16;
    localparam int TAPS   = 16;
    localparam int OUT_W  = 20;
    localparam int ACC_W  = IN_W + COEF_W + $clog2(TAPS);
    localparam int PTR_W  = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_t;

    // Symmetric inverse-sinc compensator, Q1.15, taps sum to 32768 (unity DC gain).
    localparam logic signed [COEF_W-1:0] COEF [TAPS] = '{
        -16'sd64,   16'sd96,   -16'sd160,  16'sd256,
        -16'sd448,  16'sd768,  -16'sd1536, 16'sd17472,
         16'sd17472, -16'sd1536, 16'sd768, -16'sd448,
         16'sd256,  -16'sd160,  16'sd96,   -16'sd64
    };

endpackage

// File: rtl/cic_comp_fir_comp_mac.sv
// Registered multiplier, full-precision accumulator, round-half-up and saturation.
module comp_mac
    import cic_comp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     mac_en,
    input  logic                     finish,
    input  logic signed [IN_W-1:0]   sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [OUT_W-1:0]  result,
    output logic                     result_valid
);

    localparam int PROD_W = IN_W + COEF_W;
    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(2 ** (COEF_W - 2));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [PROD_W-1:0] prod;
    logic                     prod_vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [OUT_W-1:0]  sat_val;

    // Round the accumulator back to sample scale and clamp to the output range.
    always_comb begin
        acc_rnd = acc + RND;
        acc_shr = acc_rnd >>> (COEF_W - 1);
        if (acc_shr > SAT_HI) begin
            sat_val = SAT_HI[OUT_W-1:0];
        end else if (acc_shr < SAT_LO) begin
            sat_val = SAT_LO[OUT_W-1:0];
        end else begin
            sat_val = acc_shr[OUT_W-1:0];
        end
    end

    // Product register feeds the accumulator one cycle later; result latched on finish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod         <= '0;
            prod_vld     <= 1'b0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            prod_vld <= mac_en;
            if (mac_en) begin
                prod <= sample * coef;
            end
            if (clear) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + ACC_W'(prod);
            end
            result_valid <= finish;
            if (finish) begin
                result <= sat_val;
            end
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR with decimate-by-2, one shared MAC, TAPS cycles per output.
//
// state | meaning
// IDLE  | waiting; samples (or the held sample) are written to the buffer
// MAC   | TAPS cycles, one tap product issued per cycle
// DRAIN | last registered product is accumulated
// OUT   | rounded/saturated result is latched in the MAC unit
module cic_comp_fir
    import cic_comp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_W-1:0]         in,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    logic signed [IN_W-1:0]  buf_mem [TAPS];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        tap;
    logic [PTR_W-1:0]        rd_idx;
    logic                    phase;
    logic                    hold_full;
    logic [IN_W-1:0]         hold_data;
    state_t                  state;

    logic                    wr_en;
    logic [IN_W-1:0]         wr_raw;
    logic                    trigger;
    logic signed [OUT_W-1:0] res;
    logic                    res_valid;

    // Pick what gets written this cycle: the held sample has priority over a new one.
    always_comb begin
        wr_en  = 1'b0;
        wr_raw = in;
        if (state == IDLE) begin
            if (hold_full) begin
                wr_en  = 1'b1;
                wr_raw = hold_data;
            end else if (in_valid) begin
                wr_en = 1'b1;
            end
        end
    end

    assign trigger = wr_en & phase;
    assign rd_idx  = wr_ptr - PTR_W'(1) - tap;

    // Sample buffer, write pointer, decimation phase, hold register and overrun flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr    <= '0;
            phase     <= 1'b0;
            hold_full <= 1'b0;
            hold_data <= '0;
            overrun   <= 1'b0;
        end else begin
            if (wr_en) begin
                buf_mem[wr_ptr] <= {~wr_raw[IN_W-1], wr_raw[IN_W-2:0]};
                wr_ptr          <= wr_ptr + PTR_W'(1);
                phase           <= ~phase;
            end
            if (state == IDLE) begin
                if (hold_full) begin
                    hold_full <= in_valid;
                    if (in_valid) begin
                        hold_data <= in;
                    end
                end
            end else if (in_valid) begin
                if (!hold_full) begin
                    hold_full <= 1'b1;
                    hold_data <= in;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // Sweep sequencer with registered busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            tap   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= MAC;
                        tap   <= '0;
                        busy  <= 1'b1;
                    end
                end
                MAC: begin
                    tap <= tap + PTR_W'(1);
                    if (tap == PTR_W'(TAPS - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= OUT;
                end
                OUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    comp_mac u_mac (
        .clk          (clk),
        .rst          (rst),
        .clear        (trigger),
        .mac_en       (state == MAC),
        .finish       (state == OUT),
        .sample       (buf_mem[rd_idx]),
        .coef         (COEF[tap]),
        .result       (res),
        .result_valid (res_valid)
    );

    // Output register: holds the last sample, single-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= res_valid;
            if (res_valid) begin
                out <= res;
            end
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: table-driven impulse/step vectors plus corner sequences.
`timescale 1ns/1ps
module tb_cic_comp_fir;

    localparam int MID = 262144;

    logic               clk = 1'b0;
    logic               rst;
    logic [18:0]        in;
    logic               in_valid;
    logic signed [19:0] out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [18:0] din;
        bit          exp_valid;
        int          exp_out;
    } vec_t;

    vec_t imp_tbl  [18];
    vec_t step_tbl [18];
    int   imp_exp  [8];
    int   step_exp [8];

    always #5 clk = ~clk;

    cic_comp_fir dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in       = 19'(MID);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One sample, then watch 63 cycles: pulse count, first-pulse latency, busy cycles, value.
    task automatic send(input logic [18:0] v, output int pulses, output int lat,
                        output int busy_cyc, output int val);
        @(negedge clk);
        in       = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in       = 19'(MID);
        pulses   = 0;
        lat      = -1;
        busy_cyc = 0;
        val      = 0;
        for (int i = 0; i < 63; i++) begin
            if (busy) busy_cyc++;
            if (out_valid) begin
                pulses++;
                if (lat < 0) lat = i;
                val = int'(out);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int p, l, b, v;
        int total;

        imp_exp  = '{3, 8, 23, 533, -47, -14, -5, -2};
        step_exp = '{256, 1024, 3584, 131072, 258559, 261119, 261887, 262143};
        for (int i = 0; i < 18; i++) begin
            imp_tbl[i].din       = (i == 0) ? 19'(MID + 1000) : 19'(MID);
            imp_tbl[i].exp_valid = (i % 2 == 1);
            imp_tbl[i].exp_out   = (i < 16 && i % 2 == 1) ? imp_exp[i / 2] : 0;
            step_tbl[i].din       = 19'd524287;
            step_tbl[i].exp_valid = (i % 2 == 1);
            step_tbl[i].exp_out   = (i < 16) ? step_exp[i / 2] : 262143;
        end

        rst      = 1'b0;
        in       = 19'(MID);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out", out, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        rst = 1'b1;

        // Midscale: every output zero, one output per two samples.
        total = 0;
        for (int i = 0; i < 40; i++) begin
            send(19'(MID), p, l, b, v);
            total += p;
            check($sformatf("mid[%0d] pulses", i), p, (i % 2));
            if (p != 0) check($sformatf("mid[%0d] out", i), v, 0);
            if (i == 1 || i == 39) begin
                check($sformatf("mid[%0d] latency", i), l, 19);
                check($sformatf("mid[%0d] busy cycles", i), b, 18);
            end
        end
        check("mid total pulses", total, 20);

        // Impulse of +1000 on a zero history.
        for (int i = 0; i < 18; i++) begin
            send(imp_tbl[i].din, p, l, b, v);
            check($sformatf("imp[%0d] pulses", i), p, imp_tbl[i].exp_valid ? 1 : 0);
            if (imp_tbl[i].exp_valid) check($sformatf("imp[%0d] out", i), v, imp_tbl[i].exp_out);
        end

        // Full-scale step from reset.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            send(step_tbl[i].din, p, l, b, v);
            check($sformatf("step[%0d] pulses", i), p, step_tbl[i].exp_valid ? 1 : 0);
            if (step_tbl[i].exp_valid) check($sformatf("step[%0d] out", i), v, step_tbl[i].exp_out);
        end

        // Back-to-back: x=2000 held, x=5000 dropped during a sweep.
        do_reset();
        send(19'(MID + 1000), p, l, b, v);
        check("b2b a pulses", p, 0);
        @(negedge clk);
        in       = 19'(MID);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        in       = 19'(MID + 2000);
        in_valid = 1'b1;
        @(negedge clk);
        in       = 19'(MID + 5000);
        @(negedge clk);
        in_valid = 1'b0;
        in       = 19'(MID);
        check("b2b overrun set", overrun, 1);
        p = 0;
        v = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                p++;
                v = int'(out);
            end
            @(negedge clk);
        end
        check("b2b sweep pulses", p, 1);
        check("b2b sweep out", v, 3);
        send(19'(MID), p, l, b, v);
        check("b2b held pulses", p, 1);
        check("b2b held out", v, 14);
        check("b2b overrun sticky", overrun, 1);
        do_reset();
        check("b2b overrun cleared", overrun, 0);

        // Reset during MAC cycle 5 of a sweep.
        send(19'(MID + 1000), p, l, b, v);
        send(19'(MID + 1000), p, l, b, v);
        check("rst pre pulses", p, 1);
        check("rst pre out", v, 1);
        send(19'(MID + 1000), p, l, b, v);
        @(negedge clk);
        in       = 19'(MID + 1000);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in       = 19'(MID);
        repeat (5) @(negedge clk);
        check("rst busy before", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst busy after", busy, 0);
        check("rst out after", out, 0);
        check("rst out_valid after", out_valid, 0);
        p = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) p++;
            @(negedge clk);
        end
        check("rst discarded pulses", p, 0);
        send(19'(MID), p, l, b, v);
        check("rst post s0 pulses", p, 0);
        send(19'(MID), p, l, b, v);
        check("rst post s1 pulses", p, 1);
        check("rst post s1 out", v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Downstream stage of the per-microphone CIC decimator.
- Consumes the 19-bit CIC output once per decimated sample, strobed by a single-cycle valid.
- Applies a symmetric FIR compensating the CIC passband droop, decimates by 2, and emits signed samples to the beamformer delay/sum path.
- Time-multiplexed: one multiplier, one accumulator, TAPS clock cycles per output.

Parameters:
- IN_W, 19, CIC output width (unsigned, offset-binary).
- COEF_W, 16, signed coefficient width (Q1.15).
- TAPS, 16, FIR length; even, at least 4, power of two.
- OUT_W, 20, signed output width.
- ACC_W, IN_W+COEF_W+$clog2(TAPS), accumulator width (39 at defaults).

Ports:
- clk  in  1  system clock, the same clock driving the CIC integrators.
- rst  in  1  synchronous reset, active-low; sampled on clk rising edge.
- in  in  IN_W  CIC output sample.
- in_valid  in  1  one-cycle strobe: `in` holds a new CIC sample (synchronised dec_clk edge).
- out  out  OUT_W  filtered, decimated signed sample; holds its value between strobes.
- out_valid  out  1  one-cycle strobe marking a new `out`.
- busy  out  1  high while a MAC sweep is in progress.
- overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst==0 at a clk edge): out=0, out_valid=0, busy=0, overrun=0, phase=0, write pointer=0, sample buffer all zero, hold register empty, FSM=IDLE. Reset overrides everything, including a sweep in progress; a partial result is discarded and never output.
- Input conversion: the MSB of `in` is inverted, giving signed x = in - 2^(IN_W-1). Midscale input therefore filters to 0.
- Sample buffer: circular, TAPS entries of signed IN_W bits. Each accepted sample is written at the write pointer, and the pointer increments modulo TAPS.
- Decimation phase toggles on each accepted sample. A sample accepted with phase==1 triggers a sweep. Consequence: the 1st sample after reset gives no output, the 2nd does, then every 2nd.
- Accepted while IDLE: written on the same edge it is sampled.
- in_valid while busy: the sample goes to a 1-deep hold register and is written in the first IDLE cycle after the sweep, then processed normally.
- in_valid while busy with the hold register already full: sample dropped, overrun<=1, phase unchanged.
- FSM:
  - IDLE -> MAC on trigger.
  - MAC: TAPS cycles. Cycle k reads sample[newest-k] and coef[k], products are registered, and the accumulator adds the registered product.
  - MAC -> DRAIN (1 cycle, last product accumulated) -> OUT (1 cycle) -> IDLE.
- Arithmetic:
  - Products are signed IN_W x COEF_W; the accumulator is ACC_W bits, full precision, with no intermediate overflow.
  - In OUT: r = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), i.e. round-half-up, then saturated to OUT_W signed, range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: out_valid rises exactly TAPS+3 clk cycles after the edge that accepted the triggering sample (19 at defaults). `out` updates on the same edge and out_valid is high for exactly one cycle.
- busy is high from the cycle after the trigger through the OUT cycle inclusive.
- Throughput requirement: the in_valid spacing must be at least TAPS+4 cycles to avoid using the hold register. The system ratio is 64, so this holds at defaults.

Decomposition:
- Package cic_comp_pkg holds:
  - the TAPS coefficient constant array (symmetric inverse-sinc compensator, sum = 2^15, DC gain 1.0);
  - default widths;
  - FSM state enum {IDLE, MAC, DRAIN, OUT}.
- One natural sub-module: comp_mac, holding the registered multiplier, accumulator, round and saturate logic. It takes clear/enable and presents the final result.
- Buffer, pointer, phase and FSM stay in the top level.

Test Plan:
- Reset, then 40 samples of in=262144 (midscale) at 64-cycle spacing -> 20 out_valid pulses, all out=0; first out_valid 19 cycles after the 2nd in_valid; busy high 18 cycles per sweep.
- Impulse: one sample in=262144+1000 then midscale -> outputs equal round(1000*coef[k]/2^15) for even k (first output at k=1 slot per phase: check the alignment against the model), bit-exact to the reference model.
- Full-scale step: in=524287 held -> output settles at 262143 (DC gain 1); any coefficient overshoot saturates at 524287, never wrapping negative.
- Back-to-back: in_valid on consecutive cycles during a sweep -> 1st is held and processed after the sweep, 2nd is dropped, overrun=1 and stays 1 until rst=0.
- Reset mid-sweep: rst=0 at MAC cycle 5 -> no out_valid; all outputs and state return to reset values; the next two samples produce one output computed with zero history.
